serial_adder: RTL and testbench

- Bit-serial adder built around a single full-adder stage with a registered carry.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds one bit per clock, LSB first, and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Next step after the combinational full adder: trades latency for area and is the first clocked arithmetic stage.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage with a registered carry, one bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' input).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, acc_q, sum_q;
  logic [WIDTH-1:0] acc_d, b_load;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, c_next, s_bit, c_load;
  logic             in_ready_q, out_valid_q, busy_q;

  always_comb begin
    s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    c_next = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
    // New sum bit enters at the MSB so after WIDTH shifts bit i lines up with operand bit i.
    acc_d  = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
`ifdef SERIAL_ADDER_SUB_EN
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : carry_in;
`else
    b_load = b;
    c_load = carry_in;
`endif
  end

  // acc_q is the working shift register; sum_q only updates on entry to DONE so the
  // visible result holds through IDLE and SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sr_q     <= a;
            b_sr_q     <= b_load;
            c_q        <= c_load;
            cnt_q      <= '0;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          acc_q  <= acc_d;
          c_q    <= c_next;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            sum_q       <= acc_d;
            cout_q      <= c_next;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against a transaction-level model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 0, cin8 = 0, ordy8 = 1, sub8 = 0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8, ov8, co8, bz8;
  logic [7:0] s8;

  logic       iv1 = 0, cin1 = 0, ordy1 = 1, sub1 = 0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ir1, ov1, co1, bz1;
  logic [0:0] s1;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .carry_in(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .sum(s8), .carry_out(co8), .busy(bz8));

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .carry_in(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(ov1), .out_ready(ordy1), .sum(s1), .carry_out(co1), .busy(bz1));

  // Transaction model: result is plain arithmetic, timing is "WIDTH cycles busy, then hold until taken".
  typedef struct {
    bit          idle;
    int          left;
    bit          valid;
    logic [32:0] pend;
    logic [32:0] res;
  } ms_t;

  localparam ms_t MRST = '{idle: 1'b1, left: 0, valid: 1'b0, pend: '0, res: '0};
  ms_t m8 = MRST;
  ms_t m1 = MRST;

  function automatic ms_t mstep(ms_t s, int w, bit iv, logic [31:0] a, logic [31:0] b,
                                bit cin, bit sub, bit ordy);
    ms_t         n    = s;
    logic [32:0] mask = (33'd1 << w) - 33'd1;
    if (s.idle) begin
      if (iv) begin
        n.idle = 1'b0;
        n.left = w;
        if (sub) n.pend = {1'b0, a} + ((~{1'b0, b}) & mask) + 33'd1;
        else     n.pend = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      end
    end else if (s.left > 0) begin
      n.left = s.left - 1;
      if (n.left == 0) begin
        n.valid = 1'b1;
        n.res   = s.pend;
      end
    end else if (s.valid && ordy) begin
      n.valid = 1'b0;
      n.idle  = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 = MRST;
      m1 = MRST;
    end else begin
      m8 = mstep(m8, 8, iv8, 32'(a8), 32'(b8), cin8, sub8, ordy8);
      m1 = mstep(m1, 1, iv1, 32'(a1), 32'(b1), cin1, sub1, ordy1);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cyc8", {ir8, ov8, bz8, co8, s8}, {m8.idle, m8.valid, (m8.left > 0), m8.res[8], m8.res[7:0]});
    chk("cyc1", {ir1, ov1, bz1, co1, s1}, {m1.idle, m1.valid, (m1.left > 0), m1.res[1], m1.res[0]});
  end

  task automatic wait_rdy8(input string nm);
    int n = 0;
    while (!ir8 && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_rdy"}, 64'(ir8), 64'd1);
  endtask

  // One WIDTH=8 operation with out_ready=1; latency counted inclusive of the accept edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub,
                     input logic [8:0] exp, input string nm);
    int n = 0;
    @(negedge clk);
    wait_rdy8(nm);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1;
    @(posedge clk);
    while (n < 100) begin
      @(negedge clk);
      iv8 = 0;
      n++;
      if (ov8) break;
    end
    chk({nm, "_lat"}, 64'(n), 64'd9);
    chk({nm, "_res"}, {co8, s8}, exp);
    @(negedge clk);
    chk({nm, "_rdy_after"}, {ir8, ov8}, 2'b10);
  endtask

  task automatic op1(input bit a, input bit b, input bit cin, input logic [1:0] exp, input string nm);
    int n = 0;
    @(negedge clk);
    chk({nm, "_rdy"}, 64'(ir1), 64'd1);
    a1 = a; b1 = b; cin1 = cin; iv1 = 1;
    @(posedge clk);
    while (n < 100) begin
      @(negedge clk);
      iv1 = 0;
      n++;
      if (ov1) break;
    end
    chk({nm, "_lat"}, 64'(n), 64'd2);
    chk({nm, "_res"}, {co1, s1}, exp);
  endtask

  initial begin
    int n, hs8, hs1;
    logic [15:0] tt;

    repeat (3) @(negedge clk);
    chk("reset_state", {ir8, ov8, bz8, co8, s8}, 12'h800);
    #2 rst_n = 1;

    op8(8'h5A, 8'h33, 0, 0, 9'h08D, "add_5a_33");
    op8(8'hFF, 8'h01, 0, 0, 9'h100, "add_ff_01");
    op8(8'hFF, 8'hFF, 1, 0, 9'h1FF, "add_ff_ff_c");

    // Backpressure with new operands offered throughout.
    @(negedge clk);
    wait_rdy8("bp");
    ordy8 = 0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; iv8 = 1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11;
    n = 0;
    while (!ov8 && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid", 64'(ov8), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {ir8, ov8, co8, s8}, 11'h230);
    end
    ordy8 = 1;
    @(posedge clk);
    @(negedge clk);
    wait_rdy8("bp2");
    @(posedge clk);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      iv8 = 0;
      n++;
      if (ov8) break;
    end
    chk("bp_next_res", {co8, s8}, 9'h088);

    // Asynchronous reset three shift cycles into an operation.
    @(negedge clk);
    wait_rdy8("rst_mid");
    a8 = 8'hAA; b8 = 8'h55; iv8 = 1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 chk("rst_mid_outs", {ir8, ov8, bz8, co8, s8}, 12'h800);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_no_valid", {ov8, bz8}, 2'b00);
    op8(8'h01, 8'h02, 0, 0, 9'h003, "post_rst");

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h10, 8'h01, 0, 1, 9'h10F, "sub_10_01");
    op8(8'h01, 8'h02, 1, 1, 9'h0FF, "sub_01_02");
`endif

    // Full-adder truth table, {cout,sum} for index {a,b,cin}.
    tt = 16'hE994;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      op1(idx[2], idx[1], idx[0], tt[2*i +: 2], $sformatf("w1_fa%0d", i));
    end

    // Random traffic on both instances; the every-cycle compare does the checking.
    hs8 = 0;
    hs1 = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      iv8   = ($urandom_range(0, 2) != 0);
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      cin8  = 1'($urandom);
      ordy8 = ($urandom_range(0, 3) != 0);
      iv1   = 1'($urandom);
      a1    = 1'($urandom);
      b1    = 1'($urandom);
      cin1  = 1'($urandom);
      ordy1 = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub8  = 1'($urandom);
      sub1  = 1'($urandom);
`endif
      if (ov8 && ordy8) hs8++;
      if (ov1 && ordy1) hs1++;
    end
    chk("rand_progress8", 64'(hs8 > 20), 64'd1);
    chk("rand_progress1", 64'(hs1 > 20), 64'd1);

    @(negedge clk);
    iv8 = 0; iv1 = 0; ordy8 = 1; ordy1 = 1; sub8 = 0; sub1 = 0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
